// File: rtl/n1_sagu.sv
// N1 stack address generation unit: serialises parameter/return stack push and pop
// requests onto the stack bus and steers the DSP stack-pointer arithmetic.
// Optional stack bounds checking is enabled by defining N1_SAGU_BOUNDS_CHECK_EN.
module n1_sagu #(
    parameter int SP_WIDTH = 12
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    output logic                sbus_cyc_o,
    output logic                sbus_stb_o,
    output logic                sbus_we_o,
    output logic [SP_WIDTH-1:0] sbus_adr_o,
    output logic [15:0]         sbus_dat_o,
    input  logic                sbus_ack_i,
    input  logic [15:0]         sbus_dat_i,
    input  logic                prs2sagu_psp_push_i,
    input  logic                prs2sagu_psp_pop_i,
    input  logic                prs2sagu_rsp_push_i,
    input  logic                prs2sagu_rsp_pop_i,
    input  logic [15:0]         prs2sagu_push_data_i,
    output logic                sagu2prs_ack_o,
    output logic [15:0]         sagu2prs_pull_data_o,
    output logic                sagu2dsp_psp_hold_o,
    output logic                sagu2dsp_psp_op_sel_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_psp_offs_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_psp_next_o,
    output logic                sagu2dsp_rsp_hold_o,
    output logic                sagu2dsp_rsp_op_sel_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_rsp_offs_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_rsp_next_o,
    input  logic [SP_WIDTH-1:0] dsp2sagu_psp_i,
    input  logic [SP_WIDTH-1:0] dsp2sagu_rsp_i,
    output logic [3:0]          sagu2excpt_flags_o
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Request kind: bit 1 selects the return stack, bit 0 marks a pop.
    // The kind value doubles as the index of its exception flag.
    localparam logic [1:0] KIND_PS_PUSH = 2'b00;
    localparam logic [1:0] KIND_PS_POP  = 2'b01;
    localparam logic [1:0] KIND_RS_PUSH = 2'b10;
    localparam logic [1:0] KIND_RS_POP  = 2'b11;

    localparam logic [SP_WIDTH-1:0] SP_ONE  = SP_WIDTH'(1);
    localparam logic [SP_WIDTH-1:0] SP_ONES = '1;

    state_t        state_reg;
    state_t        state_next;
    logic [1:0]    kind_reg;
    logic [1:0]    kind_next;
    logic [15:0]   data_reg;
    logic [15:0]   data_next;

    logic [3:0]    req_vec;
    logic          req_any;
    logic [1:0]    sel_kind;
    logic          sel_err;
    logic          bus_done;
    logic [SP_WIDTH-1:0] access_adr;

    assign req_vec  = {prs2sagu_rsp_pop_i, prs2sagu_rsp_push_i,
                       prs2sagu_psp_pop_i, prs2sagu_psp_push_i};
    assign req_any  = |req_vec;
    assign bus_done = (state_reg == ST_ACCESS) && sbus_ack_i;

    always_comb begin
        sel_kind = KIND_PS_PUSH;
        if (req_vec[3]) begin
            sel_kind = KIND_RS_POP;
        end else if (req_vec[2]) begin
            sel_kind = KIND_RS_PUSH;
        end else if (req_vec[1]) begin
            sel_kind = KIND_PS_POP;
        end
    end

    // PS grows upward from 0, RS grows downward from all-ones; pointers name the next free word.
    always_comb begin
        case (kind_reg)
            KIND_PS_PUSH: access_adr = dsp2sagu_psp_i;
            KIND_PS_POP:  access_adr = dsp2sagu_psp_i - SP_ONE;
            KIND_RS_PUSH: access_adr = dsp2sagu_rsp_i;
            default:      access_adr = dsp2sagu_rsp_i + SP_ONE;
        endcase
    end

`ifdef N1_SAGU_BOUNDS_CHECK_EN
    localparam logic [SP_WIDTH:0] FREE_RESET = {1'b1, {SP_WIDTH{1'b0}}};
    localparam logic [SP_WIDTH:0] FREE_ONE   = (SP_WIDTH+1)'(1);

    logic [SP_WIDTH:0] free_reg;
    logic [SP_WIDTH:0] free_next;
    logic [3:0]        flags_reg;
    logic [3:0]        flags_next;
    logic [3:0]        err_vec;

    always_comb begin
        case (sel_kind)
            KIND_PS_POP: sel_err = (dsp2sagu_psp_i == '0);
            KIND_RS_POP: sel_err = (dsp2sagu_rsp_i == SP_ONES);
            default:     sel_err = (free_reg == '0);
        endcase
    end

    assign err_vec = ((state_reg == ST_IDLE) && req_any && sel_err) ?
                     (4'b0001 << sel_kind) : 4'b0000;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_flag
            assign flags_next[gi] = flags_reg[gi] | err_vec[gi];
        end
    endgenerate

    always_comb begin
        free_next = free_reg;
        if (bus_done) begin
            free_next = kind_reg[0] ? (free_reg + FREE_ONE) : (free_reg - FREE_ONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            free_reg  <= FREE_RESET;
            flags_reg <= 4'b0000;
        end else begin
            free_reg  <= free_next;
            flags_reg <= flags_next;
        end
    end

    assign sagu2excpt_flags_o = flags_reg;
`else
    assign sel_err            = 1'b0;
    assign sagu2excpt_flags_o = 4'b0000;
`endif

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_reg <= ST_INIT;
            kind_reg  <= KIND_PS_PUSH;
            data_reg  <= 16'h0000;
        end else begin
            state_reg <= state_next;
            kind_reg  <= kind_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_INIT: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_any) begin
                    kind_next  = sel_kind;
                    data_next  = prs2sagu_push_data_i;
                    state_next = sel_err ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (sbus_ack_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced to their quiet values while reset is held, so a late
    // bus acknowledge can never leak through as a request completion.
    always_comb begin
        sbus_cyc_o            = 1'b0;
        sbus_stb_o            = 1'b0;
        sbus_we_o             = 1'b0;
        sbus_adr_o            = '0;
        sbus_dat_o            = 16'h0000;
        sagu2prs_ack_o        = 1'b0;
        sagu2prs_pull_data_o  = 16'h0000;
        sagu2dsp_psp_hold_o   = 1'b1;
        sagu2dsp_psp_op_sel_o = 1'b0;
        sagu2dsp_psp_offs_o   = '0;
        sagu2dsp_psp_next_o   = '0;
        sagu2dsp_rsp_hold_o   = 1'b1;
        sagu2dsp_rsp_op_sel_o = 1'b0;
        sagu2dsp_rsp_offs_o   = '0;
        sagu2dsp_rsp_next_o   = '0;
        if (!sync_rst_i) begin
            case (state_reg)
                ST_INIT: begin
                    sagu2dsp_psp_hold_o   = 1'b0;
                    sagu2dsp_rsp_hold_o   = 1'b0;
                    sagu2dsp_psp_op_sel_o = 1'b1;
                    sagu2dsp_rsp_op_sel_o = 1'b1;
                    sagu2dsp_rsp_next_o   = SP_ONES;
                end
                ST_ACCESS: begin
                    sbus_cyc_o = 1'b1;
                    sbus_stb_o = 1'b1;
                    sbus_we_o  = ~kind_reg[0];
                    sbus_adr_o = access_adr;
                    sbus_dat_o = kind_reg[0] ? 16'h0000 : data_reg;
                    if (sbus_ack_i) begin
                        sagu2prs_ack_o       = 1'b1;
                        sagu2prs_pull_data_o = sbus_dat_i;
                        if (kind_reg[1]) begin
                            sagu2dsp_rsp_hold_o = 1'b0;
                            sagu2dsp_rsp_offs_o = kind_reg[0] ? SP_ONE : SP_ONES;
                        end else begin
                            sagu2dsp_psp_hold_o = 1'b0;
                            sagu2dsp_psp_offs_o = kind_reg[0] ? SP_ONES : SP_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    sagu2prs_ack_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n1_sagu.sv
// Self-checking bench for n1_sagu: DSP pointer model, wait-state bus slave memory,
// a directed vector table, corner-case sequences and a queue-based random run.
module tb_n1_sagu;

    localparam int SPW = 12;
    localparam logic [SPW-1:0] TOP = 12'hFFF;
    localparam logic [1:0] K_PSH = 2'd0;
    localparam logic [1:0] K_PPO = 2'd1;
    localparam logic [1:0] K_RSH = 2'd2;
    localparam logic [1:0] K_RPO = 2'd3;

    logic           clk = 1'b0;
    logic           sync_rst;
    logic           sbus_cyc, sbus_stb, sbus_we;
    logic [SPW-1:0] sbus_adr;
    logic [15:0]    sbus_dat_o;
    logic           sbus_ack;
    logic [15:0]    sbus_dat_i;
    logic           psp_push, psp_pop, rsp_push, rsp_pop;
    logic [15:0]    push_data;
    logic           prs_ack;
    logic [15:0]    pull_data;
    logic           psp_hold, psp_op_sel, rsp_hold, rsp_op_sel;
    logic [SPW-1:0] psp_offs, psp_next, rsp_offs, rsp_next;
    logic [SPW-1:0] psp = 12'h007;
    logic [SPW-1:0] rsp = 12'h005;
    logic [3:0]     flags;

    int   total = 0;
    int   bad = 0;
    int   slave_wait = 0;
    int   wcnt = 0;
    logic ack_reg = 1'b0;
    logic force_ack = 1'b0;
    logic [15:0] mem [0:(1<<SPW)-1];

    always #5 clk = ~clk;

    n1_sagu #(.SP_WIDTH(SPW)) dut (
        .clk_i(clk), .sync_rst_i(sync_rst),
        .sbus_cyc_o(sbus_cyc), .sbus_stb_o(sbus_stb), .sbus_we_o(sbus_we),
        .sbus_adr_o(sbus_adr), .sbus_dat_o(sbus_dat_o),
        .sbus_ack_i(sbus_ack), .sbus_dat_i(sbus_dat_i),
        .prs2sagu_psp_push_i(psp_push), .prs2sagu_psp_pop_i(psp_pop),
        .prs2sagu_rsp_push_i(rsp_push), .prs2sagu_rsp_pop_i(rsp_pop),
        .prs2sagu_push_data_i(push_data),
        .sagu2prs_ack_o(prs_ack), .sagu2prs_pull_data_o(pull_data),
        .sagu2dsp_psp_hold_o(psp_hold), .sagu2dsp_psp_op_sel_o(psp_op_sel),
        .sagu2dsp_psp_offs_o(psp_offs), .sagu2dsp_psp_next_o(psp_next),
        .sagu2dsp_rsp_hold_o(rsp_hold), .sagu2dsp_rsp_op_sel_o(rsp_op_sel),
        .sagu2dsp_rsp_offs_o(rsp_offs), .sagu2dsp_rsp_next_o(rsp_next),
        .dsp2sagu_psp_i(psp), .dsp2sagu_rsp_i(rsp),
        .sagu2excpt_flags_o(flags)
    );

    // DSP pointer unit: set or add offset whenever hold is released
    always @(posedge clk) begin
        if (!psp_hold) psp <= psp_op_sel ? psp_next : psp + psp_offs;
        if (!rsp_hold) rsp <= rsp_op_sel ? rsp_next : rsp + rsp_offs;
    end

    // Bus slave: slave_wait=0 acks combinationally, otherwise after slave_wait cyc cycles
    assign sbus_ack   = ack_reg | force_ack | ((slave_wait == 0) && sbus_cyc && sbus_stb);
    assign sbus_dat_i = sbus_ack ? mem[sbus_adr] : 16'h0000;

    always @(posedge clk) begin
        if (sbus_cyc && sbus_stb && !sbus_ack && slave_wait != 0) begin
            if (wcnt >= slave_wait - 1) begin
                ack_reg <= 1'b1;
                wcnt    <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            ack_reg <= 1'b0;
            wcnt    <= 0;
        end
        if (sbus_cyc && sbus_stb && sbus_ack && sbus_we) mem[sbus_adr] <= sbus_dat_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] kind, input logic val);
        case (kind)
            K_PSH:   psp_push = val;
            K_PPO:   psp_pop  = val;
            K_RSH:   rsp_push = val;
            default: rsp_pop  = val;
        endcase
    endtask

    // Waits (bounded) for the completion pulse; lat counts the request cycle too.
    task automatic wait_ack(output int lat, output int cycs, output logic we,
                            output logic [SPW-1:0] adr, output logic [15:0] wdat,
                            output logic [15:0] pull);
        logic ok;
        lat = 1; cycs = 0; ok = 1'b0;
        we = 1'b0; adr = '0; wdat = 16'h0; pull = 16'h0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lat++;
            if (sbus_cyc) cycs++;
            if (prs_ack) begin
                we = sbus_we; adr = sbus_adr; wdat = sbus_dat_o; pull = pull_data;
                ok = 1'b1;
                break;
            end
        end
        check("ack_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_req(input logic [1:0] kind, input logic [15:0] data, input int wt,
                          output int lat, output int cycs, output logic we,
                          output logic [SPW-1:0] adr, output logic [15:0] wdat,
                          output logic [15:0] pull);
        slave_wait = wt;
        push_data  = data;
        set_req(kind, 1'b1);
        wait_ack(lat, cycs, we, adr, wdat, pull);
        set_req(kind, 1'b0);
        $display("txn kind=%0d wait=%0d we=%0d adr=%03h wdat=%04h pull=%04h lat=%0d",
                 kind, wt, we, adr, wdat, pull, lat);
        @(negedge clk);
        check("ack_single_pulse", 32'(prs_ack), 32'd0);
    endtask

    typedef struct {
        logic [1:0]     kind;
        logic [15:0]    data;
        int             wt;
        logic [SPW-1:0] exp_adr;
        logic [15:0]    exp_dat;
        logic [SPW-1:0] exp_psp;
        logic [SPW-1:0] exp_rsp;
    } vec_t;

    vec_t vecs [8];
    int lat, cycs;
    logic we;
    logic [SPW-1:0] adr, exp_adr;
    logic [15:0] wdat, pull, data, exp_pull;
    logic [1:0] kind;
    logic err, seen;
    int wt;
    logic [3:0] exp_flags;
    logic [15:0] ps_q[$];
    logic [15:0] rs_q[$];

    initial begin
        vecs[0] = '{K_PSH, 16'h1234, 1, 12'h000, 16'h1234, 12'h001, 12'hFFF};
        vecs[1] = '{K_PSH, 16'hBEEF, 0, 12'h001, 16'hBEEF, 12'h002, 12'hFFF};
        vecs[2] = '{K_RSH, 16'h5A5A, 2, 12'hFFF, 16'h5A5A, 12'h002, 12'hFFE};
        vecs[3] = '{K_RSH, 16'h0F0F, 0, 12'hFFE, 16'h0F0F, 12'h002, 12'hFFD};
        vecs[4] = '{K_PPO, 16'h0000, 1, 12'h001, 16'hBEEF, 12'h001, 12'hFFD};
        vecs[5] = '{K_RPO, 16'h0000, 0, 12'hFFE, 16'h0F0F, 12'h001, 12'hFFE};
        vecs[6] = '{K_RPO, 16'h0000, 3, 12'hFFF, 16'h5A5A, 12'h001, 12'hFFF};
        vecs[7] = '{K_PPO, 16'h0000, 0, 12'h000, 16'h1234, 12'h000, 12'hFFF};

        sync_rst = 1'b1;
        psp_push = 1'b0; psp_pop = 1'b0; rsp_push = 1'b0; rsp_pop = 1'b0;
        push_data = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(sbus_cyc), 32'd0);
        check("rst_ack", 32'(prs_ack), 32'd0);
        check("rst_rsp_next", 32'(rsp_next), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);

        // Reset release: one INIT cycle loads PSP=0 and RSP=all-ones
        sync_rst = 1'b0;
        #1;
        check("init_psp_hold", 32'(psp_hold), 32'd0);
        check("init_rsp_hold", 32'(rsp_hold), 32'd0);
        check("init_op_sel", 32'({psp_op_sel, rsp_op_sel}), 32'd3);
        check("init_rsp_next", 32'(rsp_next), 32'(TOP));
        @(negedge clk);
        check("init_psp", 32'(psp), 32'd0);
        check("init_rsp", 32'(rsp), 32'(TOP));
        check("idle_hold", 32'({psp_hold, rsp_hold}), 32'd3);
        check("init_flags", 32'(flags), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].kind, vecs[i].data, vecs[i].wt, lat, cycs, we, adr, wdat, pull);
            check("tbl_we", 32'(we), 32'(!vecs[i].kind[0]));
            check("tbl_adr", 32'(adr), 32'(vecs[i].exp_adr));
            if (vecs[i].kind[0]) check("tbl_pull", 32'(pull), 32'(vecs[i].exp_dat));
            else                 check("tbl_wdat", 32'(wdat), 32'(vecs[i].exp_dat));
            check("tbl_lat", 32'(lat), 32'(vecs[i].wt + 2));
            check("tbl_psp", 32'(psp), 32'(vecs[i].exp_psp));
            check("tbl_rsp", 32'(rsp), 32'(vecs[i].exp_rsp));
        end

        // Simultaneous RS pop and PS push: RS pop is served first
        do_req(K_RSH, 16'hCAFE, 1, lat, cycs, we, adr, wdat, pull);
        check("prio_setup_adr", 32'(adr), 32'(TOP));
        slave_wait = 1;
        push_data  = 16'h7777;
        rsp_pop    = 1'b1;
        psp_push   = 1'b1;
        wait_ack(lat, cycs, we, adr, wdat, pull);
        rsp_pop = 1'b0;
        check("prio_first_we", 32'(we), 32'd0);
        check("prio_first_adr", 32'(adr), 32'(TOP));
        check("prio_first_pull", 32'(pull), 32'h0000CAFE);
        wait_ack(lat, cycs, we, adr, wdat, pull);
        psp_push = 1'b0;
        check("prio_second_we", 32'(we), 32'd1);
        check("prio_second_adr", 32'(adr), 32'd0);
        check("prio_second_wdat", 32'(wdat), 32'h00007777);
        @(negedge clk);
        check("prio_psp", 32'(psp), 32'd1);
        check("prio_rsp", 32'(rsp), 32'(TOP));
        do_req(K_PPO, 16'h0, 0, lat, cycs, we, adr, wdat, pull);
        check("prio_pop_pull", 32'(pull), 32'h00007777);
        check("prio_pop_psp", 32'(psp), 32'd0);

        // PS pop on an empty parameter stack
        do_req(K_PPO, 16'h0, 0, lat, cycs, we, adr, wdat, pull);
        check("pop_empty_lat", 32'(lat), 32'd2);
`ifdef N1_SAGU_BOUNDS_CHECK_EN
        check("pop_empty_cyc", 32'(cycs), 32'd0);
        check("pop_empty_pull", 32'(pull), 32'd0);
        check("pop_empty_flags", 32'(flags), 32'b0010);
        check("pop_empty_psp", 32'(psp), 32'd0);
`else
        check("pop_wrap_adr", 32'(adr), 32'(TOP));
        check("pop_wrap_psp", 32'(psp), 32'(TOP));
        check("pop_wrap_flags", 32'(flags), 32'd0);
`endif

        // Reset during ACCESS with a late bus acknowledge
        slave_wait = 10;
        push_data  = 16'h4321;
        psp_push   = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sbus_cyc) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_access_reached", 32'(seen), 32'd1);
        sync_rst = 1'b1;
        psp_push = 1'b0;
        #1;
        check("rst_mid_cyc", 32'(sbus_cyc), 32'd0);
        @(negedge clk);
        sync_rst  = 1'b0;
        force_ack = 1'b1;
        #1;
        check("rst_late_ack", 32'(prs_ack), 32'd0);
        check("rst_reinit_hold", 32'({psp_hold, rsp_hold}), 32'd0);
        @(negedge clk);
        force_ack = 1'b0;
        check("rst_reinit_psp", 32'(psp), 32'd0);
        check("rst_reinit_rsp", 32'(rsp), 32'(TOP));
        check("rst_flags_clear", 32'(flags), 32'd0);
        check("rst_no_ack", 32'(prs_ack), 32'd0);

        // Random run against a queue-per-stack model
        exp_flags = 4'b0000;
        for (int n = 0; n < 150; n++) begin
            kind = 2'($urandom_range(0, 3));
            wt   = int'($urandom_range(0, 3));
            data = 16'($urandom);
            err  = kind[0] && ((kind[1] ? rs_q.size() : ps_q.size()) == 0);
`ifndef N1_SAGU_BOUNDS_CHECK_EN
            if (err) begin
                kind[0] = 1'b0;
                err     = 1'b0;
            end
`endif
            case (kind)
                K_PSH:   exp_adr = 12'(ps_q.size());
                K_PPO:   exp_adr = 12'(ps_q.size() - 1);
                K_RSH:   exp_adr = TOP - 12'(rs_q.size());
                default: exp_adr = TOP - 12'(rs_q.size() - 1);
            endcase
            do_req(kind, data, wt, lat, cycs, we, adr, wdat, pull);
            if (err) begin
                exp_flags = exp_flags | (4'b0001 << kind);
                check("rnd_err_cyc", 32'(cycs), 32'd0);
                check("rnd_err_pull", 32'(pull), 32'd0);
                check("rnd_err_lat", 32'(lat), 32'd2);
            end else begin
                check("rnd_we", 32'(we), 32'(!kind[0]));
                check("rnd_adr", 32'(adr), 32'(exp_adr));
                check("rnd_lat", 32'(lat), 32'(wt + 2));
                if (kind[0]) begin
                    exp_pull = kind[1] ? rs_q.pop_back() : ps_q.pop_back();
                    check("rnd_pull", 32'(pull), 32'(exp_pull));
                end else begin
                    if (kind[1]) rs_q.push_back(data);
                    else         ps_q.push_back(data);
                    check("rnd_wdat", 32'(wdat), 32'(data));
                end
            end
            check("rnd_psp", 32'(psp), 32'(ps_q.size()));
            check("rnd_rsp", 32'(rsp), 32'(TOP - 12'(rs_q.size())));
            check("rnd_flags", 32'(flags), 32'(exp_flags));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
